// File: rtl/debug_uart_tx.sv
// rtl/debug_uart_tx.sv - buffered debug byte port serialized as 8N1 (or 8E1) UART
//
// Purpose: accepts one byte per strobe cycle into a small FIFO and shifts the
// bytes out LSB first on a single TX pin. When the FIFO is full, bytes are dropped
// and the loss is recorded in a sticky flag.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_debug_strobe one-cycle write pulse, one byte per high cycle
//   i_debug_data   byte qualified by i_debug_strobe
//   o_uart_tx      serial output, idle high
//   o_busy         frame on the wire or FIFO non-empty
//   o_overflow     sticky: a strobe arrived while the FIFO was full
//   o_fifo_level   current FIFO occupancy
//
// Build option: define DEBUG_UART_TX_PARITY_EN to add an even-parity bit (8E1).
module debug_uart_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_debug_strobe,
  input  logic [7:0]                  i_debug_data,
  output logic                        o_uart_tx,
  output logic                        o_busy,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("debug_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("debug_uart_tx: FIFO_DEPTH must be a power of 2, at least 2");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef DEBUG_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, level, level_n;
  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n, head;
  logic          tx, tx_n, busy, busy_n, ovf;
  logic          pop, push, full, baud_end;
`ifdef DEBUG_UART_TX_PARITY_EN
  logic          par, par_n;
`endif

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LEVEL);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign baud_end = (cnt == LAST_CNT);

  always_comb begin
    pop     = 1'b0;
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
`ifdef DEBUG_UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (level != '0) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = S_START;
          tx_n    = 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
          par_n   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          cnt_n   = '0;
          state_n = S_DATA;
          bit_n   = 3'd0;
          tx_n    = shift[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
`ifdef DEBUG_UART_TX_PARITY_EN
          par_n   = par ^ shift[0];
`endif
          if (bit_idx == 3'd7) begin
`ifdef DEBUG_UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = par ^ shift[0];
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = shift[1];
          end
        end
      end
`ifdef DEBUG_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          cnt_n   = '0;
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          cnt_n = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (level != '0) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = S_START;
            tx_n    = 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
            par_n   = 1'b0;
`endif
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
    // A pop on the same edge frees the slot, so a full FIFO still takes the byte.
    push    = i_debug_strobe & (~full | pop);
    level_n = level + (AW+1)'(push) - (AW+1)'(pop);
    busy_n  = (state_n != S_IDLE) | (level_n != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
`ifdef DEBUG_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
      busy    <= busy_n;
`ifdef DEBUG_UART_TX_PARITY_EN
      par     <= par_n;
`endif
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (i_debug_strobe && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_debug_data;
  end

  assign o_uart_tx    = tx;
  assign o_busy       = busy;
  assign o_overflow   = ovf;
  assign o_fifo_level = level;

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb/tb_debug_uart_tx.sv - randomized self-checking bench for debug_uart_tx
`timescale 1ns/1ps
module tb_debug_uart_tx;

  localparam int CLK_FREQ_HZ = 1000000;
  localparam int BAUD        = 100000;
  localparam int FIFO_DEPTH  = 16;
  localparam int DIV         = 10;
`ifdef DEBUG_UART_TX_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strobe = 1'b0;
  logic [7:0] data = 8'd0;
  logic       tx, busy, ovf;
  logic [4:0] level;

  debug_uart_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD(BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_debug_strobe(strobe),
    .i_debug_data(data),
    .o_uart_tx(tx),
    .o_busy(busy),
    .o_overflow(ovf),
    .o_fifo_level(level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: every accepted byte with its strobe cycle and its frame start cycle.
  int         q_push[$];
  int         q_start[$];
  logic [7:0] q_data[$];
  bit         m_ovf;

  logic       s_tx, s_busy, s_ovf;
  logic [4:0] s_level;
  int         max_lvl;
  bit         hit, found;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // A byte sits in the FIFO from the cycle after its strobe until the cycle before its start bit.
  function automatic int m_level(int t);
    int n = 0;
    foreach (q_push[i]) if (q_push[i] + 1 <= t && t <= q_start[i] - 1) n++;
    return n;
  endfunction

  function automatic bit m_pop(int t);
    foreach (q_start[i]) if (q_start[i] - 1 == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(int t);
    foreach (q_push[i]) if (q_push[i] + 1 <= t && t < q_start[i] + FL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_tx(int t);
    foreach (q_start[i]) begin
      if (t >= q_start[i] && t < q_start[i] + FL) begin
        int slot;
        slot = (t - q_start[i]) / DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return q_data[i][slot-1];
`ifdef DEBUG_UART_TX_PARITY_EN
        if (slot == 9) return ^q_data[i];
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  // Earliest start is two cycles after the strobe, but never before the previous frame ends.
  function automatic void commit(int n, logic [7:0] d);
    int st;
    if (m_level(n) < FIFO_DEPTH || m_pop(n)) begin
      st = n + 2;
      if (q_start.size() > 0 && q_start[$] + FL > st) st = q_start[$] + FL;
      q_push.push_back(n);
      q_start.push_back(st);
      q_data.push_back(d);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  // Entered and left one time unit after a rising edge.
  task automatic step(input bit stb, input logic [7:0] d);
    strobe = stb;
    data   = d;
    @(negedge clk);
    s_tx    = tx;
    s_busy  = busy;
    s_ovf   = ovf;
    s_level = level;
    check("tx", s_tx, m_tx(cyc));
    check("busy", s_busy, m_busy(cyc));
    check("level", s_level, m_level(cyc));
    check("overflow", s_ovf, m_ovf);
    if (stb) commit(cyc, d);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    q_push.delete();
    q_start.delete();
    q_data.delete();
    m_ovf = 1'b0;
    cyc = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single byte: start bit, LSB-first data, stop bit and busy fall.
    for (int t = 0; t < 130; t++) begin
      step(t == 0, 8'h55);
      if (t == 1)  check("b_wait_tx", s_tx, 1);
      if (t == 2)  check("b_start_low", s_tx, 0);
      if (t == 11) check("b_start_end", s_tx, 0);
      if (t == 12) check("b_bit0", s_tx, 1);
      if (t == 22) check("b_bit1", s_tx, 0);
      if (t == 91) check("b_bit7", s_tx, 0);
      if (t == 2 + FL - 1) check("b_busy_last", s_busy, 1);
      if (t == 2 + FL) check("b_busy_fall", s_busy, 0);
    end

    // 18 back-to-back strobes: the last one is dropped.
    do_reset();
    max_lvl = 0;
    for (int t = 0; t < 1900; t++) begin
      step(t < 18, 8'(t));
      if (int'(s_level) > max_lvl) max_lvl = int'(s_level);
    end
    check("c_overflow", s_ovf, 1);
    check("c_peak_level", max_lvl, 16);
    check("c_idle", s_busy, 0);

    // A byte after an overflow is still accepted; the flag stays set.
    step(1'b1, 8'hFF);
    for (int t = 0; t < 130; t++) step(1'b0, 8'h00);
    check("d_ovf_sticky", s_ovf, 1);
    check("d_idle", s_busy, 0);

    // Strobe while full on the same edge as a STOP->START pop.
    do_reset();
    found = 1'b0;
    for (int t = 0; t < 17; t++) step(1'b1, 8'($urandom));
    for (int t = 0; t < 300; t++) begin
      hit = !found && m_pop(cyc) && (m_level(cyc) == FIFO_DEPTH);
      if (hit) check("e_full_before", s_level, 16);
      step(hit, 8'($urandom));
      if (hit) begin
        found = 1'b1;
        step(1'b0, 8'h00);
        check("e_level_kept", s_level, 16);
        check("e_no_ovf", s_ovf, 0);
      end
    end

    // Random traffic with a dense burst, enough to overflow.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      step(($urandom_range(0, 29) == 0) || (t >= 1000 && t < 1030), 8'($urandom));
    end

    // Parity-relevant bytes 0x07 and 0x03.
    do_reset();
    for (int t = 0; t < 2 * FL + 20; t++) begin
      step(t < 2, (t == 0) ? 8'h07 : 8'h03);
      if (t == 2 + 95) check("g_slot9_first", s_tx, 1);
`ifdef DEBUG_UART_TX_PARITY_EN
      if (t == 2 + FL + 95) check("g_slot9_second", s_tx, 0);
`else
      if (t == 2 + FL + 95) check("g_slot9_second", s_tx, 1);
`endif
      if (t == 2 + 2 * FL) check("g_busy_fall", s_busy, 0);
    end

    // Reset in the middle of 0xA3's data bits with three bytes queued.
    do_reset();
    for (int t = 0; t < 40; t++) step(t < 4, (t == 0) ? 8'hA3 : 8'($urandom));
    check("h_level_before", s_level, 3);
    check("h_tx_before", s_tx, 0);
    do_reset();
    for (int t = 0; t < 30; t++) step(1'b0, 8'h00);
    check("h_tx_after", s_tx, 1);
    check("h_busy_after", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
